ysyx_22040895_imem: RTL
=======================

YSYX_22040895_IMEM -- requirements
Module: ysyx_22040895_imem

Interface
REQ-001 Parameter BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, 4096, number of 32-bit words; power of two.
REQ-003 Parameter WAIT_CYCLES, 1, extra response latency in cycles; legal range 0..15.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 ce_i  in  1  fetch enable from the IFU; gates acceptance of new requests only.
REQ-007 req_valid_i  in  1  fetch request valid.
REQ-008 req_ready_o  out  1  block can accept a request.
REQ-009 req_addr_i  in  64  fetch byte address (InstAddrBus).
REQ-010 rsp_valid_o  out  1  response valid.
REQ-011 rsp_ready_i  in  1  core accepts the response.
REQ-012 rsp_inst_o  out  32  fetched instruction (InstBus).
REQ-013 rsp_err_o  out  1  request was misaligned or out of range.
REQ-014 ld_we_i  in  1  loader write enable.
REQ-015 ld_addr_i  in  log2(DEPTH_WORDS)  loader word index.
REQ-016 ld_data_i  in  32  loader write data.
REQ-017 busy_o  out  1  a request is in flight (state is not IDLE).

Function
REQ-018 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-019 req_ready_o SHALL equal ce_i in IDLE and SHALL be 0 in WAIT and RESP.
REQ-020 A request SHALL be accepted on an edge where req_valid_i, req_ready_o and ce_i are all 1; the block SHALL latch req_addr_i at that edge.
REQ-021 On acceptance, the FSM SHALL go to RESP if WAIT_CYCLES=0; otherwise it SHALL go to WAIT with a counter loaded to WAIT_CYCLES-1.
REQ-022 In WAIT, the counter SHALL decrement each cycle; at count 0 the FSM SHALL go to RESP.
REQ-023 rsp_valid_o SHALL rise exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-024 The memory word SHALL be read at the edge that enters RESP; rsp_inst_o and rsp_err_o SHALL be registered at that edge and stay stable while in RESP.
REQ-025 In RESP, rsp_valid_o SHALL be 1 until an edge where rsp_ready_i=1; on that edge the FSM SHALL go to IDLE and rsp_valid_o SHALL fall.
REQ-026 Maximum throughput SHALL be one request per WAIT_CYCLES+2 cycles; there is no back-to-back acceptance.
REQ-027 Error SHALL be set when latched addr[1:0]!=0, when addr<BASE_ADDR, or when addr>=BASE_ADDR+4*DEPTH_WORDS; the comparison SHALL be 64-bit with no wrap.
REQ-028 On error, rsp_err_o SHALL be 1 and rsp_inst_o SHALL be 32'h0; otherwise rsp_err_o SHALL be 0 and rsp_inst_o SHALL be the word at index (addr-BASE_ADDR)>>2.
REQ-029 A loader write SHALL update the memory at any edge where ld_we_i=1, in any state.
REQ-030 If a loader write hits the word being read at the RESP-entry edge, the response SHALL carry the old data.
REQ-031 If ce_i falls while a request is in flight, the request SHALL still complete normally.

Reset
REQ-032 While rst=1, the FSM SHALL be IDLE with rsp_valid_o=0, rsp_inst_o=32'h0, rsp_err_o=0, busy_o=0 and the counter at 0.
REQ-033 While rst=1, req_ready_o SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL abort the request immediately with no response.
REQ-035 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-036 Normal fetch: with WAIT_CYCLES=1, load word 0=32'h00000413 and request addr 0x80000000 -> rsp_valid_o rises 2 cycles after acceptance, rsp_inst_o=32'h00000413, rsp_err_o=0.
REQ-037 Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and rsp_inst_o stay stable, req_ready_o=0; raise rsp_ready_i -> IDLE next cycle.
REQ-038 Errors: addr 0x80000002 -> err=1, inst=0; addr 0x7FFFFFFC -> err=1; addr 0x80004000 (DEPTH 4096) -> err=1; addr 0x80003FFC -> err=0.
REQ-039 Edge cases: with WAIT_CYCLES=0 the response comes 1 cycle after acceptance; with ce_i=0 and req_valid_i=1 there is no acceptance and busy_o=0.
REQ-040 Loader collision: loader writes the target word on the RESP-entry edge -> old value is returned, and a later fetch returns the new value.
REQ-041 Async reset: assert rst in WAIT between edges -> busy_o=0 and rsp_valid_o=0 immediately; after release, a fetch of a preloaded word still returns its data.

Source files
------------

// File: rtl/ysyx_22040895_imem.sv
// ysyx_22040895_imem: instruction memory with valid/ready fetch port, fixed wait latency and loader write port
module ysyx_22040895_imem #(
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [63:0]                    req_addr_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [31:0]                    rsp_inst_o,
  output logic                           rsp_err_o,
  input  logic                           ld_we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr_i,
  input  logic [31:0]                    ld_data_i,
  output logic                           busy_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + 65'(DEPTH_WORDS) * 65'd4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [63:0] addr_q, rd_addr, off;
  logic [AW-1:0] idx;
  logic [31:0] rsp_inst_q;
  logic rsp_err_q, accept, load_rsp, err;
  logic [31:0] mem [DEPTH_WORDS];
  assign req_ready_o = ce_i & ~rst & (state == IDLE);
  assign accept = req_valid_i & req_ready_o;
  assign rsp_valid_o = state == RESP;
  assign busy_o = state != IDLE;
  assign rsp_inst_o = rsp_inst_q;
  assign rsp_err_o = rsp_err_q;
  // With zero wait the read happens on the acceptance edge, so use the live address while idle
  assign rd_addr = (state == IDLE) ? req_addr_i : addr_q;
  assign off = rd_addr - BASE_ADDR;
  assign idx = AW'(off >> 2);
  assign err = (|rd_addr[1:0]) | (rd_addr < BASE_ADDR) | ({1'b0, rd_addr} >= LIMIT);
  // Loader writes land on any edge and survive reset
  always_ff @(posedge clk)
    if (ld_we_i) mem[ld_addr_i] <= ld_data_i;
  // Next-state and wait counter
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    load_rsp = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) begin
          state_n = RESP;
          load_rsp = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_n = 4'(WAIT_CYCLES - 1);
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_n = RESP;
        load_rsp = 1'b1;
      end else cnt_n = cnt - 4'd1;
      RESP: if (rsp_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // State, latched address and registered response; the non-blocking read returns pre-write data on a loader collision
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      addr_q <= 64'd0;
      rsp_inst_q <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) addr_q <= req_addr_i;
      if (load_rsp) begin
        rsp_err_q <= err;
        rsp_inst_q <= err ? 32'd0 : mem[idx];
      end
    end
endmodule
